// File: rtl/alu_issue_scheduler_if.sv
// Dispatch/issue bus between the rename-dispatch stage, the ALU reservation
// stations and the ALU. The scheduler connects through the slave modport.
interface alu_issue_scheduler_if #(
    parameter int ALU = 2,
    parameter int ROB = 2
);
    logic [ALU:0] ALURequests;
    logic [ROB:0] instrRob;
    logic [ALU:0] stationReady;
    logic         flush;
    logic         fuReady;
    logic [ALU:0] ALUBusyVector;
    logic         issueValid;
    logic [ALU:0] issueGrant;
    logic [ROB:0] issueRob;

    // Dispatch / ALU side: drives allocations and handshake, observes issue
    modport master (
        output ALURequests, instrRob, stationReady, flush, fuReady,
        input  ALUBusyVector, issueValid, issueGrant, issueRob
    );

    // Scheduler side
    modport slave (
        input  ALURequests, instrRob, stationReady, flush, fuReady,
        output ALUBusyVector, issueValid, issueGrant, issueRob
    );
endinterface

// File: rtl/alu_issue_scheduler.sv
// ALU issue scheduler: tracks per-station FREE/WAIT/ISSUED state and an age
// matrix, selects the oldest ready station and holds it in a registered
// valid/ready issue slot until the ALU accepts it.
module alu_issue_scheduler #(
    parameter int ALU = 2,
    parameter int ROB = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_issue_scheduler_if.slave  bus
);
    localparam int NS = ALU + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } st_e;

    st_e                  state_q [NS];
    st_e                  state_d [NS];
    logic [ALU:0][ALU:0]  older_q;       // older_q[i][j]: i allocated before j
    logic [ALU:0][ALU:0]  older_d;
    logic [ALU:0][ROB:0]  tag_q;
    logic [ALU:0][ROB:0]  tag_d;
    logic [ALU:0]         busy_q;
    logic [ALU:0]         busy_d;
    logic                 valid_q;
    logic                 valid_d;
    logic [ALU:0]         grant_q;
    logic [ALU:0]         grant_d;
    logic [ROB:0]         rob_q;
    logic [ROB:0]         rob_d;

    logic [ALU:0]         cand;
    logic [ALU:0]         sel;
    logic [ROB:0]         sel_tag;
    logic [ALU:0]         freeing;
    logic                 accept;
    logic                 load;

    assign bus.ALUBusyVector = busy_q;
    assign bus.issueValid    = valid_q;
    assign bus.issueGrant    = grant_q;
    assign bus.issueRob      = rob_q;

    assign accept  = valid_q & bus.fuReady;
    assign load    = ~valid_q | accept;
    // Only the station sitting in the slot can be freed by an accept
    assign freeing = accept ? grant_q : '0;

    // Oldest-ready selection: a candidate wins when no other candidate is older
    always_comb begin
        cand    = '0;
        sel     = '0;
        sel_tag = '0;
        for (int i = 0; i < NS; i++) begin
            cand[i] = (state_q[i] == ST_WAIT) && bus.stationReady[i];
        end
        for (int i = 0; i < NS; i++) begin
            sel[i] = cand[i];
            for (int j = 0; j < NS; j++) begin
                if ((j != i) && cand[j] && older_q[j][i]) begin
                    sel[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (sel[i]) begin
                sel_tag = sel_tag | tag_q[i];
            end
        end
    end

    // Next-state for station states, age matrix, tags and issue slot
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            state_d[i] = state_q[i];
        end
        older_d = older_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        grant_d = grant_q;
        rob_d   = rob_q;
        busy_d  = '0;

        if (bus.flush) begin
            // Flush kills everything; the stale tag is harmless with valid low
            for (int i = 0; i < NS; i++) begin
                state_d[i] = ST_FREE;
            end
            older_d = '0;
            valid_d = 1'b0;
            grant_d = '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (freeing[i]) begin
                    state_d[i] = ST_FREE;
                end else if (load && sel[i]) begin
                    state_d[i] = ST_ISSUED;
                end else if (bus.ALURequests[i] && (state_q[i] == ST_FREE)) begin
                    // New entry is younger than every station that stays busy
                    state_d[i] = ST_WAIT;
                    tag_d[i]   = bus.instrRob;
                    for (int j = 0; j < NS; j++) begin
                        older_d[i][j] = 1'b0;
                        older_d[j][i] = (j != i) && (state_q[j] != ST_FREE) && !freeing[j];
                    end
                end
            end
            // A freed station drops out of every age relation
            for (int i = 0; i < NS; i++) begin
                if (freeing[i]) begin
                    for (int j = 0; j < NS; j++) begin
                        older_d[i][j] = 1'b0;
                        older_d[j][i] = 1'b0;
                    end
                end
            end
            if (load) begin
                valid_d = |sel;
                grant_d = sel;
                if (|sel) begin
                    rob_d = sel_tag;
                end
            end
        end

        for (int i = 0; i < NS; i++) begin
            busy_d[i] = (state_d[i] != ST_FREE);
        end
    end

    // Station state and registered busy vector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                state_q[i] <= ST_FREE;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                state_q[i] <= state_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Age matrix and per-station ROB tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            older_q <= '0;
            tag_q   <= '0;
        end else begin
            older_q <= older_d;
            tag_q   <= tag_d;
        end
    end

    // Issue slot presented to the ALU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            grant_q <= '0;
            rob_q   <= '0;
        end else begin
            valid_q <= valid_d;
            grant_q <= grant_d;
            rob_q   <= rob_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with hand-computed expectations.
module tb_alu_issue_scheduler;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    alu_issue_scheduler_if #(.ALU(2), .ROB(2)) bus ();

    alu_issue_scheduler #(.ALU(2), .ROB(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] rob,
                         input logic [2:0] rdy, input logic fu, input logic fl);
        bus.ALURequests  = req;
        bus.instrRob     = rob;
        bus.stationReady = rdy;
        bus.fuReady      = fu;
        bus.flush        = fl;
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] busy,
                              input logic vld, input logic [2:0] gnt, input logic [2:0] rob);
        check({tag, ".busy"}, {29'd0, bus.ALUBusyVector}, {29'd0, busy});
        check({tag, ".vld"},  {31'd0, bus.issueValid},    {31'd0, vld});
        check({tag, ".gnt"},  {29'd0, bus.issueGrant},    {29'd0, gnt});
        if (vld) check({tag, ".rob"}, {29'd0, bus.issueRob}, {29'd0, rob});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        drive(3'b000, 3'd0, 3'b000, 1'b0, 1'b0);
        #12;
        expect_out("reset", 3'b000, 1'b0, 3'b000, 3'd0);
        check("reset.rob", {29'd0, bus.issueRob}, 32'd0);
        reset_n = 1'b1;
        step();

        // Single allocation, minimum latency to issue and free
        drive(3'b001, 3'd3, 3'b001, 1'b1, 1'b0);
        step();
        expect_out("single.c1", 3'b001, 1'b0, 3'b000, 3'd0);
        drive(3'b000, 3'd0, 3'b001, 1'b1, 1'b0);
        step();
        expect_out("single.c2", 3'b001, 1'b1, 3'b001, 3'd3);
        step();
        expect_out("single.c3", 3'b000, 1'b0, 3'b000, 3'd0);

        // Age order S2, S0, S1 then all ready
        drive(3'b100, 3'd1, 3'b000, 1'b1, 1'b0); step();
        drive(3'b001, 3'd2, 3'b000, 1'b1, 1'b0); step();
        drive(3'b010, 3'd4, 3'b000, 1'b1, 1'b0); step();
        expect_out("age.alloc", 3'b111, 1'b0, 3'b000, 3'd0);
        drive(3'b000, 3'd0, 3'b111, 1'b1, 1'b0);
        step(); expect_out("age.g0", 3'b111, 1'b1, 3'b100, 3'd1);
        step(); expect_out("age.g1", 3'b011, 1'b1, 3'b001, 3'd2);
        step(); expect_out("age.g2", 3'b010, 1'b1, 3'b010, 3'd4);
        step(); expect_out("age.end", 3'b000, 1'b0, 3'b000, 3'd0);

        // Backpressure holds S1 in the slot while S0 becomes ready
        drive(3'b010, 3'd5, 3'b000, 1'b0, 1'b0); step();
        drive(3'b001, 3'd6, 3'b000, 1'b0, 1'b0); step();
        drive(3'b000, 3'd0, 3'b010, 1'b0, 1'b0); step();
        expect_out("bp.load", 3'b011, 1'b1, 3'b010, 3'd5);
        drive(3'b000, 3'd0, 3'b011, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("bp.hold", 3'b011, 1'b1, 3'b010, 3'd5);
        end
        bus.fuReady = 1'b1;
        step(); expect_out("bp.next", 3'b001, 1'b1, 3'b001, 3'd6);
        step(); expect_out("bp.end", 3'b000, 1'b0, 3'b000, 3'd0);

        // Flush beats a same-cycle accept and allocation
        drive(3'b001, 3'd1, 3'b001, 1'b0, 1'b0); step();
        drive(3'b000, 3'd0, 3'b001, 1'b0, 1'b0); step();
        expect_out("flush.pre", 3'b001, 1'b1, 3'b001, 3'd1);
        drive(3'b100, 3'd5, 3'b111, 1'b1, 1'b1); step();
        expect_out("flush.edge", 3'b000, 1'b0, 3'b000, 3'd0);
        drive(3'b000, 3'd0, 3'b111, 1'b1, 1'b0); step();
        expect_out("flush.after", 3'b000, 1'b0, 3'b000, 3'd0);

        // Allocation to a busy station is ignored; alloc and accept together
        drive(3'b010, 3'd3, 3'b000, 1'b0, 1'b0); step();
        drive(3'b001, 3'd2, 3'b000, 1'b0, 1'b0); step();
        drive(3'b010, 3'd7, 3'b000, 1'b0, 1'b0); step();
        expect_out("busyalloc", 3'b011, 1'b0, 3'b000, 3'd0);
        drive(3'b000, 3'd0, 3'b011, 1'b1, 1'b0); step();
        expect_out("busyalloc.g0", 3'b011, 1'b1, 3'b010, 3'd3);
        drive(3'b100, 3'd6, 3'b111, 1'b1, 1'b0); step();
        expect_out("allocacc.g1", 3'b101, 1'b1, 3'b001, 3'd2);
        drive(3'b000, 3'd0, 3'b111, 1'b1, 1'b0); step();
        expect_out("allocacc.g2", 3'b100, 1'b1, 3'b100, 3'd6);
        step(); expect_out("allocacc.end", 3'b000, 1'b0, 3'b000, 3'd0);

        // Asynchronous reset in the middle of activity
        drive(3'b001, 3'd1, 3'b001, 1'b0, 1'b0); step();
        drive(3'b010, 3'd2, 3'b001, 1'b0, 1'b0); step();
        drive(3'b000, 3'd0, 3'b001, 1'b0, 1'b0);
        expect_out("rstmid.pre", 3'b011, 1'b1, 3'b001, 3'd1);
        #2 reset_n = 1'b0;
        #1;
        expect_out("rstmid.async", 3'b000, 1'b0, 3'b000, 3'd0);
        check("rstmid.rob", {29'd0, bus.issueRob}, 32'd0);
        #3 reset_n = 1'b1;
        step(); step();
        expect_out("rstmid.idle", 3'b000, 1'b0, 3'b000, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
